mem_access_stage: RTL

Pipelined CPU memory stage: consumes the EX/MEM pipeline register outputs, performs loads and stores against a data memory over a valid/ready request and response handshake, and stalls the upstream pipeline while an access is outstanding. Its output register is the MEM/WB boundary: it presents write-back data with load alignment and sign/zero extension applied, flags misaligned or illegal accesses, and passes non-memory results through in one cycle.

---
 rtl/mem_access_stage_if.sv | 31 +++
 rtl/mem_access_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage_if
// Description : Data-memory request/response bus between the memory stage
//               (master) and the data memory (slave). Request side uses a
//               valid/ready handshake; the response is a single valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_stage_if #(
    parameter int XLEN = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [XLEN-1:0]   addr;
    logic              we;
    logic [XLEN-1:0]   wdata;
    logic [XLEN/8-1:0] wstrb;
    logic              resp_valid;
    logic [XLEN-1:0]   rdata;

    modport master (
        output req_valid, addr, we, wdata, wstrb,
        input  req_ready, resp_valid, rdata
    );

    modport slave (
        input  req_valid, addr, we, wdata, wstrb,
        output req_ready, resp_valid, rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Pipelined CPU memory stage. Issues loads/stores to data memory
//               over a valid/ready bus, stalls upstream while an access is
//               outstanding, and registers the MEM/WB boundary with load
//               alignment, sign/zero extension and access-fault flagging.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int XLEN = 64
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    // EX/MEM pipeline register
    input  wire logic             in_valid_i,
    input  wire logic [XLEN-1:0]  alu_result_i,
    input  wire logic [XLEN-1:0]  alu_input2_i,
    input  wire logic [4:0]       rd_i,
    input  wire logic [2:0]       funct3_i,
    input  wire logic             reg_write_i,
    input  wire logic             mem_read_i,
    input  wire logic             mem_write_i,
    input  wire logic             mem_reg_i,
    output logic                  stall_o,
    // Data memory bus
    mem_access_stage_if.master    dmem,
    // MEM/WB pipeline register
    output logic                  wb_valid_o,
    output logic                  wb_reg_write_o,
    output logic                  wb_mem_reg_o,
    output logic [4:0]            wb_rd_o,
    output logic [XLEN-1:0]       wb_data_o,
    output logic                  wb_exc_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q, state_d;

    // Access context captured in IDLE; the bus is driven only from these
    logic [XLEN-1:0]   addr_q;
    logic [2:0]        funct3_q;
    logic              we_q;
    logic [XLEN-1:0]   wdata_q;
    logic [7:0]        wstrb_q;
    logic [4:0]        rd_q;
    logic              reg_write_q;
    logic              mem_reg_q;

    logic              wb_valid_q;
    logic              wb_reg_write_q;
    logic              wb_mem_reg_q;
    logic [4:0]        wb_rd_q;
    logic [XLEN-1:0]   wb_data_q;
    logic              wb_exc_q;

    logic              w_mem_op;
    logic              w_misalign;
    logic              w_illegal;
    logic              w_exc;
    logic              w_start;
    logic [2:0]        w_off;
    logic [7:0]        w_wstrb;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_lane;
    logic [XLEN-1:0]   w_load;

    assign w_mem_op = in_valid_i & (mem_read_i | mem_write_i);
    assign w_off    = alu_result_i[2:0];
    assign w_wdata  = alu_input2_i << {w_off, 3'b000};
    assign w_start  = w_mem_op & ~w_exc;

    // Classify the incoming access: illegal encodings and size misalignment
    always_comb begin
        w_misalign = 1'b0;
        case (funct3_i[1:0])
            2'b01:   w_misalign = alu_result_i[0];
            2'b10:   w_misalign = |alu_result_i[1:0];
            2'b11:   w_misalign = |alu_result_i[2:0];
            default: w_misalign = 1'b0;
        endcase
        w_illegal = (mem_read_i & mem_write_i)
                  | (mem_read_i & (funct3_i == 3'b111))
                  | (mem_write_i & funct3_i[2]);
        w_exc     = w_mem_op & (w_illegal | w_misalign);
    end

    // Byte enables for the store size, placed at the byte offset
    always_comb begin
        w_wstrb = 8'h00;
        case (funct3_i[1:0])
            2'b00:   w_wstrb = 8'h01 << w_off;
            2'b01:   w_wstrb = 8'h03 << w_off;
            2'b10:   w_wstrb = 8'h0F << w_off;
            default: w_wstrb = 8'hFF;
        endcase
    end

    // Extract the addressed lane of the read doubleword and extend it
    always_comb begin
        w_lane = dmem.rdata >> {addr_q[2:0], 3'b000};
        case (funct3_q)
            3'b000:  w_load = {{(XLEN-8){w_lane[7]}},   w_lane[7:0]};
            3'b001:  w_load = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
            3'b010:  w_load = {{(XLEN-32){w_lane[31]}}, w_lane[31:0]};
            3'b100:  w_load = {{(XLEN-8){1'b0}},        w_lane[7:0]};
            3'b101:  w_load = {{(XLEN-16){1'b0}},       w_lane[15:0]};
            3'b110:  w_load = {{(XLEN-32){1'b0}},       w_lane[31:0]};
            default: w_load = w_lane;
        endcase
    end

    // Next-state and stall; stall drops in the response cycle so EX/MEM advances
    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall_o = w_start;
                if (w_start) state_d = S_REQ;
            end
            S_REQ: begin
                stall_o = 1'b1;
                if (dmem.req_ready) state_d = S_RESP;
            end
            S_RESP: begin
                stall_o = ~dmem.resp_valid;
                if (dmem.resp_valid) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                stall_o = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Capture the access context when a legal memory op is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            funct3_q    <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_reg_q   <= 1'b0;
        end else if (state_q == S_IDLE && w_start) begin
            addr_q      <= alu_result_i;
            funct3_q    <= funct3_i;
            we_q        <= mem_write_i;
            wdata_q     <= w_wdata;
            wstrb_q     <= w_wstrb;
            rd_q        <= rd_i;
            reg_write_q <= reg_write_i;
            mem_reg_q   <= mem_reg_i;
        end
    end

    // MEM/WB register: pass-through in IDLE, memory result on response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_mem_reg_q   <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            wb_exc_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_start) begin
                        wb_valid_q     <= 1'b0;
                    end else begin
                        wb_valid_q     <= in_valid_i;
                        wb_data_q      <= alu_result_i;
                        wb_rd_q        <= rd_i;
                        wb_reg_write_q <= reg_write_i & ~w_exc;
                        wb_mem_reg_q   <= mem_reg_i;
                        wb_exc_q       <= w_exc;
                    end
                end
                S_RESP: begin
                    if (dmem.resp_valid) begin
                        wb_valid_q     <= 1'b1;
                        wb_rd_q        <= rd_q;
                        wb_reg_write_q <= reg_write_q;
                        wb_mem_reg_q   <= mem_reg_q;
                        wb_exc_q       <= 1'b0;
                        wb_data_q      <= (!we_q && mem_reg_q) ? w_load : addr_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem.req_valid = (state_q == S_REQ);
    assign dmem.addr      = {addr_q[XLEN-1:3], 3'b000};
    assign dmem.we        = we_q;
    assign dmem.wdata     = wdata_q;
    assign dmem.wstrb     = wstrb_q;

    assign wb_valid_o     = wb_valid_q;
    assign wb_reg_write_o = wb_reg_write_q;
    assign wb_mem_reg_o   = wb_mem_reg_q;
    assign wb_rd_o        = wb_rd_q;
    assign wb_data_o      = wb_data_q;
    assign wb_exc_o       = wb_exc_q;

endmodule
`default_nettype wire
